// File: rtl/alu_seq_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_unit
// Description : Sequential ALU for the EX stage of the multi-cycle datapath.
//               Decodes i_ALUop / i_funct into a 4-bit ALU control code,
//               latches the operands on a start handshake and produces the
//               result itself. Single-cycle ops finish with latency 1.
//               Variable shifts take 1+shamt cycles and multiply takes
//               1+WIDTH cycles, using one step per cycle.
//
// Ports       : i_clk      rising-edge clock
//               i_rst      synchronous active-high reset
//               i_start    operation request, taken only while o_busy = 0
//               i_ALUop    operation class from the control FSM
//               i_funct    R-type funct field (used when i_ALUop = 010)
//               i_a, i_b   operands (i_b[SHAMT_W-1:0] = shift amount)
//               o_busy     high from the cycle after accept through o_done
//               o_done     one-cycle pulse, result valid
//               o_result   registered result, held until the next o_done
//               o_zero     (o_result == 0), updated together with o_result
//               o_ALUctrl  decoded control code of the last accepted op
//               o_illegal  set with o_done on an undefined decode
//
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [2:0]         i_ALUop,
    input  logic [5:0]         i_funct,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_busy,
    output logic               o_done,
    output logic [WIDTH-1:0]   o_result,
    output logic               o_zero,
    output logic [3:0]         o_ALUctrl,
    output logic               o_illegal
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [3:0] c_CTRL_AND  = 4'b0000;
    localparam logic [3:0] c_CTRL_OR   = 4'b0001;
    localparam logic [3:0] c_CTRL_ADD  = 4'b0010;
    localparam logic [3:0] c_CTRL_SUB  = 4'b0110;
    localparam logic [3:0] c_CTRL_SLT  = 4'b0111;
    localparam logic [3:0] c_CTRL_NOR  = 4'b1000;
    localparam logic [3:0] c_CTRL_DIV2 = 4'b1001;
    localparam logic [3:0] c_CTRL_SRAV = 4'b1010;
    localparam logic [3:0] c_CTRL_XOR  = 4'b1011;
    localparam logic [3:0] c_CTRL_MUL  = 4'b1100;
    localparam logic [3:0] c_CTRL_SRLV = 4'b1101;
    localparam logic [3:0] c_CTRL_SLLV = 4'b1110;
    localparam logic [3:0] c_CTRL_ILL  = 4'b1111;

    // Iteration counter must hold WIDTH itself, hence one extra bit.
    localparam logic [SHAMT_W:0] c_K_MUL   = (SHAMT_W+1)'(WIDTH);
    localparam logic [SHAMT_W:0] c_CNT_ONE = (SHAMT_W+1)'(1);

    // ------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------
    logic [1:0]         r_state_q,   w_state_d;
    logic [SHAMT_W:0]   r_cnt_q,     w_cnt_d;
    logic [WIDTH-1:0]   r_acc_q,     w_acc_d;     // working value / product
    logic [WIDTH-1:0]   r_opa_q,     w_opa_d;     // multiplicand (shifts left)
    logic [WIDTH-1:0]   r_opb_q,     w_opb_d;     // multiplier (shifts right)
    logic [3:0]         r_ctrl_q,    w_ctrl_d;
    logic               r_done_q,    w_done_d;
    logic [WIDTH-1:0]   r_result_q,  w_result_d;
    logic               r_zero_q,    w_zero_d;
    logic               r_illegal_q, w_illegal_d;

    logic [3:0]         w_dec_ctrl;
    logic [3:0]         w_funct_ctrl;
    logic [WIDTH-1:0]   w_single_res;
    logic [WIDTH-1:0]   w_load_val;
    logic [SHAMT_W:0]   w_k_init;
    logic               w_slt;
    logic               w_busy;
    logic               w_accept;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // The done cycle still counts as busy, so a start coinciding with
    // o_done is dropped even though the FSM is already back in IDLE.
    assign w_busy   = (r_state_q != c_ST_IDLE) | r_done_q;
    assign w_accept = i_start & ~w_busy;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    always_comb begin
        w_funct_ctrl = c_CTRL_ILL;
        case (i_funct)
            6'b000000: w_funct_ctrl = c_CTRL_ADD;
            6'b100000: w_funct_ctrl = c_CTRL_ADD;
            6'b100010: w_funct_ctrl = c_CTRL_SUB;
            6'b100100: w_funct_ctrl = c_CTRL_AND;
            6'b100101: w_funct_ctrl = c_CTRL_OR;
            6'b101010: w_funct_ctrl = c_CTRL_SLT;
            6'b100110: w_funct_ctrl = c_CTRL_XOR;
            6'b100111: w_funct_ctrl = c_CTRL_NOR;
            6'b000100: w_funct_ctrl = c_CTRL_SLLV;
            6'b000110: w_funct_ctrl = c_CTRL_SRLV;
            6'b000111: w_funct_ctrl = c_CTRL_SRAV;
            6'b011000: w_funct_ctrl = c_CTRL_MUL;
            6'b000010: w_funct_ctrl = c_CTRL_DIV2;
            default:   w_funct_ctrl = c_CTRL_ILL;
        endcase
    end

    always_comb begin
        w_dec_ctrl = c_CTRL_ILL;
        case (i_ALUop)
            3'b000:  w_dec_ctrl = c_CTRL_ADD;
            3'b001:  w_dec_ctrl = c_CTRL_SUB;
            3'b010:  w_dec_ctrl = w_funct_ctrl;
            3'b011:  w_dec_ctrl = c_CTRL_AND;
            3'b100:  w_dec_ctrl = c_CTRL_SLT;
            3'b101:  w_dec_ctrl = c_CTRL_SLLV;
            3'b110:  w_dec_ctrl = c_CTRL_XOR;
            default: w_dec_ctrl = c_CTRL_DIV2;
        endcase
    end

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the live operands at accept
    // ------------------------------------------------------------------
    assign w_slt = ($signed(i_a) < $signed(i_b));

    always_comb begin
        w_single_res = '0;
        case (w_dec_ctrl)
            c_CTRL_ADD:  w_single_res = i_a + i_b;
            c_CTRL_SUB:  w_single_res = i_a - i_b;
            c_CTRL_AND:  w_single_res = i_a & i_b;
            c_CTRL_OR:   w_single_res = i_a | i_b;
            c_CTRL_XOR:  w_single_res = i_a ^ i_b;
            c_CTRL_NOR:  w_single_res = ~(i_a | i_b);
            c_CTRL_SLT:  w_single_res = {{(WIDTH-1){1'b0}}, w_slt};
            c_CTRL_DIV2: w_single_res = {i_a[WIDTH-1], i_a[WIDTH-1:1]};
            // Illegal and iterative ops load zero here; iterative ops
            // take their start value from w_load_val instead.
            default:     w_single_res = '0;
        endcase
    end

    // Initial working value and iteration count for the accepted op.
    always_comb begin
        w_load_val = w_single_res;
        w_k_init   = '0;
        case (w_dec_ctrl)
            c_CTRL_SLLV,
            c_CTRL_SRLV,
            c_CTRL_SRAV: begin
                w_load_val = i_a;
                w_k_init   = {1'b0, i_b[SHAMT_W-1:0]};
            end
            c_CTRL_MUL: begin
                w_load_val = '0;
                w_k_init   = c_K_MUL;
            end
            default: begin
                w_load_val = w_single_res;
                w_k_init   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_acc_d     = r_acc_q;
        w_opa_d     = r_opa_q;
        w_opb_d     = r_opb_q;
        w_ctrl_d    = r_ctrl_q;
        w_done_d    = 1'b0;
        w_result_d  = r_result_q;
        w_zero_d    = r_zero_q;
        w_illegal_d = r_illegal_q;

        case (r_state_q)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_ctrl_d    = w_dec_ctrl;
                    w_illegal_d = 1'b0;
                    w_cnt_d     = w_k_init;
                    w_acc_d     = w_load_val;
                    w_opa_d     = i_a;
                    w_opb_d     = i_b;
                    w_state_d   = (w_k_init == '0) ? c_ST_DONE : c_ST_EXEC;
                end
            end

            c_ST_EXEC: begin
                w_cnt_d = r_cnt_q - c_CNT_ONE;
                case (r_ctrl_q)
                    c_CTRL_SLLV: w_acc_d = {r_acc_q[WIDTH-2:0], 1'b0};
                    c_CTRL_SRLV: w_acc_d = {1'b0, r_acc_q[WIDTH-1:1]};
                    c_CTRL_SRAV: w_acc_d = {r_acc_q[WIDTH-1], r_acc_q[WIDTH-1:1]};
                    c_CTRL_MUL: begin
                        // Shift-add: the multiplier LSB gates the add, then
                        // both operands move one place for the next bit.
                        w_acc_d = r_opb_q[0] ? (r_acc_q + r_opa_q) : r_acc_q;
                        w_opa_d = {r_opa_q[WIDTH-2:0], 1'b0};
                        w_opb_d = {1'b0, r_opb_q[WIDTH-1:1]};
                    end
                    default:     w_acc_d = r_acc_q;
                endcase
                if (r_cnt_q == c_CNT_ONE) begin
                    w_state_d = c_ST_DONE;
                end
            end

            c_ST_DONE: begin
                w_done_d    = 1'b1;
                w_result_d  = r_acc_q;
                w_zero_d    = (r_acc_q == '0);
                w_illegal_d = (r_ctrl_q == c_CTRL_ILL);
                w_state_d   = c_ST_IDLE;
            end

            default: begin
                w_state_d = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q   <= c_ST_IDLE;
            r_cnt_q     <= '0;
            r_acc_q     <= '0;
            r_opa_q     <= '0;
            r_opb_q     <= '0;
            r_ctrl_q    <= c_CTRL_ADD;
            r_done_q    <= 1'b0;
            r_result_q  <= '0;
            r_zero_q    <= 1'b1;
            r_illegal_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_acc_q     <= w_acc_d;
            r_opa_q     <= w_opa_d;
            r_opb_q     <= w_opb_d;
            r_ctrl_q    <= w_ctrl_d;
            r_done_q    <= w_done_d;
            r_result_q  <= w_result_d;
            r_zero_q    <= w_zero_d;
            r_illegal_q <= w_illegal_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_busy    = w_busy;
    assign o_done    = r_done_q;
    assign o_result  = r_result_q;
    assign o_zero    = r_zero_q;
    assign o_ALUctrl = r_ctrl_q;
    assign o_illegal = r_illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_unit
// Description : Scoreboard bench for alu_seq_unit (WIDTH = 32). Each issued
//               operation pushes its expected result, control code, illegal
//               flag and latency; the entry is popped and compared when
//               o_done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_unit;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    logic              clk;
    logic              i_rst;
    logic              i_start;
    logic [2:0]        i_ALUop;
    logic [5:0]        i_funct;
    logic [WIDTH-1:0]  i_a;
    logic [WIDTH-1:0]  i_b;
    logic              o_busy;
    logic              o_done;
    logic [WIDTH-1:0]  o_result;
    logic              o_zero;
    logic [3:0]        o_ALUctrl;
    logic              o_illegal;

    alu_seq_unit #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_ALUop   (i_ALUop),
        .i_funct   (i_funct),
        .i_a       (i_a),
        .i_b       (i_b),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_result  (o_result),
        .o_zero    (o_zero),
        .o_ALUctrl (o_ALUctrl),
        .o_illegal (o_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count of rising edges; read at negedges for latency measurement.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  ctrl;
        logic        ill;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op (called at a negedge) and push its expectation.
    task automatic issue(input logic [2:0] aluop, input logic [5:0] funct,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [3:0] ctrl,
                         input logic ill, input int lat);
        exp_t e;
        int guard;
        guard = 0;
        while (o_busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (o_busy) check_val("issue_wait_timeout", 32'(o_busy), 32'd0);
        i_ALUop = aluop;
        i_funct = funct;
        i_a     = a;
        i_b     = b;
        i_start = 1'b1;
        e.res  = res;
        e.ctrl = ctrl;
        e.ill  = ill;
        e.lat  = lat;
        e.acc  = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        i_start = 1'b0;
        i_a     = 32'hDEAD_BEEF;  // operands are don't-care after accept
        i_b     = 32'h0BAD_F00D;
        check_val("busy_after_accept", 32'(o_busy), 32'd1);
    endtask

    // Wait for o_done, pop and compare. inject_at >= 0 pulses i_start with
    // a different op at that wait cycle; start_on_done pulses i_start in the
    // done cycle. Both must be ignored by the DUT.
    task automatic wait_done(input string tag, input int budget,
                             input int inject_at, input bit start_on_done);
        exp_t e;
        bit   got;
        int   extra;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            i_start = (i == inject_at);
            if (i == inject_at) begin
                i_ALUop = 3'b000;
                i_a     = 32'h1111_1111;
                i_b     = 32'h2222_2222;
            end
            @(negedge clk);
            i_start = 1'b0;
            if (o_done) begin
                got = 1'b1;
                e = sb.pop_front();
                check_val({tag, "_result"},  o_result,          e.res);
                check_val({tag, "_zero"},    32'(o_zero),       32'(e.res == 32'd0));
                check_val({tag, "_ctrl"},    32'(o_ALUctrl),    32'(e.ctrl));
                check_val({tag, "_illegal"}, 32'(o_illegal),    32'(e.ill));
                check_val({tag, "_latency"}, 32'(cyc - e.acc),  32'(e.lat));
                check_val({tag, "_busy_done"}, 32'(o_busy),     32'd1);
            end
        end
        if (!got) begin
            check_val({tag, "_done_timeout"}, 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            if (start_on_done) begin
                i_ALUop = 3'b000;
                i_a     = 32'h5;
                i_b     = 32'h6;
                i_start = 1'b1;
            end
            @(negedge clk);
            i_start = 1'b0;
            check_val({tag, "_busy_after_done"}, 32'(o_busy), 32'd0);
            extra = 0;
            for (int i = 0; i < 3; i++) begin
                if (o_done) extra++;
                @(negedge clk);
            end
            check_val({tag, "_extra_done"}, 32'(extra), 32'd0);
        end
    endtask

    initial begin
        int dones;
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_ALUop = 3'b000;
        i_funct = 6'b000000;
        i_a     = '0;
        i_b     = '0;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;

        // Reset state
        check_val("rst_result",  o_result,         32'd0);
        check_val("rst_zero",    32'(o_zero),      32'd1);
        check_val("rst_busy",    32'(o_busy),      32'd0);
        check_val("rst_done",    32'(o_done),      32'd0);
        check_val("rst_ctrl",    32'(o_ALUctrl),   32'h2);
        check_val("rst_illegal", 32'(o_illegal),   32'd0);
        @(negedge clk);

        // Single-cycle ops
        issue(3'b010, 6'b100010, 32'd5, 32'd7, 32'hFFFF_FFFE, 4'b0110, 1'b0, 1);
        wait_done("sub_funct", 10, -1, 1'b0);
        issue(3'b100, 6'b000000, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0111, 1'b0, 1);
        wait_done("slt_neg", 10, -1, 1'b0);
        issue(3'b100, 6'b000000, 32'd1, 32'hFFFF_FFFF, 32'd0, 4'b0111, 1'b0, 1);
        wait_done("slt_pos", 10, -1, 1'b0);
        issue(3'b111, 6'b000000, 32'h8000_0004, 32'd0, 32'hC000_0002, 4'b1001, 1'b0, 1);
        wait_done("div2", 10, -1, 1'b1);
        issue(3'b001, 6'b000000, 32'd3, 32'd3, 32'd0, 4'b0110, 1'b0, 1);
        wait_done("sub_zero", 10, -1, 1'b0);
        issue(3'b011, 6'b000000, 32'hF0F0_FF00, 32'h0FF0_0FF0, 32'h00F0_0F00, 4'b0000, 1'b0, 1);
        wait_done("and", 10, -1, 1'b0);
        issue(3'b010, 6'b100101, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 4'b0001, 1'b0, 1);
        wait_done("or", 10, -1, 1'b0);
        issue(3'b010, 6'b100111, 32'hF000_0001, 32'h0000_0F00, 32'h0FFF_F0FE, 4'b1000, 1'b0, 1);
        wait_done("nor", 10, -1, 1'b0);
        issue(3'b110, 6'b000000, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 4'b1011, 1'b0, 1);
        wait_done("xor", 10, -1, 1'b0);
        issue(3'b010, 6'b000000, 32'hFFFF_FFFF, 32'd2, 32'd1, 4'b0010, 1'b0, 1);
        wait_done("nop_add_wrap", 10, -1, 1'b0);

        // Shifts
        issue(3'b101, 6'b000000, 32'd1, 32'd31, 32'h8000_0000, 4'b1110, 1'b0, 32);
        wait_done("sllv_31", 40, -1, 1'b0);
        issue(3'b010, 6'b000111, 32'h8000_0000, 32'd4, 32'hF800_0000, 4'b1010, 1'b0, 5);
        wait_done("srav_4", 20, -1, 1'b0);
        issue(3'b010, 6'b000110, 32'h8000_0000, 32'd4, 32'h0800_0000, 4'b1101, 1'b0, 5);
        wait_done("srlv_4", 20, -1, 1'b0);
        issue(3'b101, 6'b000000, 32'h1234_5678, 32'd0, 32'h1234_5678, 4'b1110, 1'b0, 1);
        wait_done("sllv_0", 10, -1, 1'b0);
        issue(3'b010, 6'b000100, 32'd3, 32'h0000_0021, 32'd6, 4'b1110, 1'b0, 2);
        wait_done("sllv_hi_bits", 10, -1, 1'b0);

        // Multiply, with an ignored start mid-operation
        issue(3'b010, 6'b011000, 32'h0001_0003, 32'h0001_0002, 32'h0005_0006, 4'b1100, 1'b0, 33);
        wait_done("mul", 45, 10, 1'b0);

        // Illegal decode, then a legal op clears o_illegal
        issue(3'b010, 6'b111111, 32'd9, 32'd9, 32'd0, 4'b1111, 1'b1, 1);
        wait_done("illegal", 10, -1, 1'b0);
        issue(3'b000, 6'b000000, 32'd7, 32'd9, 32'd16, 4'b0010, 1'b0, 1);
        wait_done("add_after_ill", 10, -1, 1'b0);

        // Reset mid-multiply aborts without o_done
        issue(3'b010, 6'b011000, 32'h0000_0007, 32'h0000_0009, 32'd63, 4'b1100, 1'b0, 33);
        repeat (9) @(negedge clk);
        i_rst   = 1'b1;
        i_start = 1'b1;   // reset wins over a simultaneous start
        @(negedge clk);
        i_rst   = 1'b0;
        i_start = 1'b0;
        check_val("rst_mid_busy", 32'(o_busy), 32'd0);
        check_val("rst_mid_done", 32'(o_done), 32'd0);
        void'(sb.pop_back());
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_done) dones++;
            @(negedge clk);
        end
        check_val("rst_mid_no_done", 32'(dones), 32'd0);
        issue(3'b000, 6'b000000, 32'd2, 32'd3, 32'd5, 4'b0010, 1'b0, 1);
        wait_done("add_after_rst", 10, -1, 1'b0);

        check_val("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
